counter_run_ctrl: RTL and testbench
===================================

// Module: counter_run_ctrl
// PURPOSE
//  Run controller for the modulo-N (default 0..6) 3-bit counter datapath.
//  Sequences the count register through start / pause / single-step / clear,
//  counts completed laps (wraps) and stops after a programmed number of laps.
//  Sits between front-panel style control inputs and the counter display bits.
// PARAMETERS
//  WIDTH        3   count register width
//  DEFAULT_MAX  6   terminal count used when MAX input is 0
//  LAP_W        4   width of lap target / lap counter
// PORTS
//  CLK      in   1       rising-edge clock; all state updates on this edge
//  RST      in   1       synchronous, active-high reset
//  START    in   1       start new run (IDLE/DONE) or resume (PAUSE)
//  PAUSE    in   1       freeze count while running
//  STEP     in   1       advance one count while paused
//  CLR      in   1       synchronous abort to IDLE
//  MAX      in   WIDTH   terminal count, sampled on run start (0 -> DEFAULT_MAX)
//  LAPS     in   LAP_W   laps before DONE, sampled on run start (0 -> run forever)
//  Q        out  WIDTH   count value (Q[2]=C, Q[1]=B, Q[0]=A for WIDTH=3)
//  WRAP     out  1       registered 1-cycle pulse, high while Q shows 0 after a wrap
//  LAP_CNT  out  LAP_W   completed laps in current run
//  BUSY     out  1       high in RUN or PAUSE
//  DONE     out  1       high in DONE state
// BEHAVIOUR
//  Reset (RST=1): state IDLE, Q=0, WRAP=0, LAP_CNT=0, BUSY=0, DONE=0,
//   max_r=DEFAULT_MAX, laps_r=0. RST overrides every other input.
//  Priority of control inputs in one cycle: RST > CLR > PAUSE > START > STEP.
//  States: IDLE, RUN, PAUSE, DONE (encoding free).
//  IDLE: START -> RUN; latch max_r=(MAX==0?DEFAULT_MAX:MAX), laps_r=LAPS;
//   Q=0, LAP_CNT=0. PAUSE/STEP ignored.
//  RUN: each edge, advance: Q==max_r ? Q=0 and wrap : Q=Q+1.
//   PAUSE -> PAUSE, Q holds that edge (no advance). START ignored.
//  PAUSE: Q holds. STEP -> one advance, stay PAUSE. START -> RUN, no relatch,
//   no advance that edge. START+STEP same cycle: START wins, no step.
//  DONE: Q=0, LAP_CNT holds final value. START -> RUN with relatch (new run).
//  Wrap (RUN or STEP): Q=0, WRAP=1 next cycle only, LAP_CNT+=1 (mod 2^LAP_W).
//   If laps_r!=0 and LAP_CNT+1==laps_r: same edge go DONE.
//  CLR (any state): -> IDLE, Q=0, LAP_CNT=0, WRAP=0; max_r/laps_r keep value.
//  MAX/LAPS changes after run start have no effect until next run start.
//  Latency: START edge k -> Q=0 at k; Q=1 at k+1; first wrap at k+max_r+1.
//   Run with laps_r=L ends at edge k+L*(max_r+1).
//  Q never exceeds max_r; if Q>max_r ever loaded (not reachable) treat as wrap.
//  Outputs BUSY/DONE decoded from state register (no combinational input path).
// TESTING
//  1 Reset: RST=1 two cycles from any state -> Q=0, WRAP=0, LAP_CNT=0,
//    BUSY=0, DONE=0; START held during RST has no effect.
//  2 Default run: MAX=0, LAPS=0, START pulse -> Q 0,1,2,3,4,5,6,0,1..;
//    WRAP every 7th edge; LAP_CNT increments; DONE never asserts (>=30 laps).
//  3 Lap stop: MAX=3, LAPS=2, START -> Q 0,1,2,3,0,1,2,3,0; 8 edges after
//    START edge DONE=1, BUSY=0, Q=0, LAP_CNT=2; Q stays 0 afterwards.
//  4 Pause/step: MAX=6 run to Q=4, PAUSE -> Q=4 held 5 cycles; STEP x3 ->
//    Q=5,6,0 with WRAP on the 0; START -> Q=1 on next advance edge.
//  5 Priority: in RUN, CLR+START same cycle -> IDLE, Q=0; PAUSE+START ->
//    PAUSE; in PAUSE, START+STEP -> RUN with Q unchanged that edge.
//  6 Mid-operation: change MAX 6->2 during RUN -> wrap still at 6; RST in
//    PAUSE -> all outputs at reset values next edge; CLR in DONE -> IDLE.

Source files
------------

// File: rtl/counter_run_ctrl.sv
// Run controller for a modulo-N count register: start / pause / single-step / clear,
// lap counting with an optional stop after a programmed number of laps.
module counter_run_ctrl #(
  parameter int WIDTH       = 3,
  parameter int DEFAULT_MAX = 6,
  parameter int LAP_W       = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             PAUSE,
  input  logic             STEP,
  input  logic             CLR,
  input  logic [WIDTH-1:0] MAX,
  input  logic [LAP_W-1:0] LAPS,
  output logic [WIDTH-1:0] Q,
  output logic             WRAP,
  output logic [LAP_W-1:0] LAP_CNT,
  output logic             BUSY,
  output logic             DONE,
  output logic [1:0]       state_dbg
);

  // Handshake: none; all control inputs are level-sampled on the rising edge of CLK,
  // one decision per cycle with priority RST > CLR > PAUSE > START > STEP.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] DEF_MAX = WIDTH'(DEFAULT_MAX);

  state_t             state_r, state_n;
  logic [WIDTH-1:0]   q_r, q_n;
  logic               wrap_r, wrap_n;
  logic [LAP_W-1:0]   lap_r, lap_n;
  logic [WIDTH-1:0]   max_r, max_n;
  logic [LAP_W-1:0]   laps_r, laps_n;

  logic               do_adv;
  logic               adv_wrap;
  logic [LAP_W-1:0]   lap_inc;

  // ">=" rather than "==" so an out-of-range count recovers as a wrap.
  assign adv_wrap = (q_r >= max_r);
  assign lap_inc  = lap_r + 1'b1;

  always_comb begin
    state_n = state_r;
    q_n     = q_r;
    wrap_n  = 1'b0;
    lap_n   = lap_r;
    max_n   = max_r;
    laps_n  = laps_r;
    do_adv  = 1'b0;

    if (CLR) begin
      state_n = S_IDLE;
      q_n     = '0;
      lap_n   = '0;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (START) begin
            state_n = S_RUN;
            max_n   = (MAX == '0) ? DEF_MAX : MAX;
            laps_n  = LAPS;
            q_n     = '0;
            lap_n   = '0;
          end
        end
        S_RUN: begin
          if (PAUSE) state_n = S_PAUSE;
          else       do_adv  = 1'b1;
        end
        S_PAUSE: begin
          if (!PAUSE) begin
            if (START)     state_n = S_RUN;
            else if (STEP) do_adv  = 1'b1;
          end
        end
        default: state_n = S_IDLE;
      endcase

      if (do_adv) begin
        if (adv_wrap) begin
          q_n    = '0;
          wrap_n = 1'b1;
          lap_n  = lap_inc;
          if ((laps_r != '0) && (lap_inc == laps_r)) state_n = S_DONE;
        end else begin
          q_n = q_r + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= S_IDLE;
      q_r     <= '0;
      wrap_r  <= 1'b0;
      lap_r   <= '0;
      max_r   <= DEF_MAX;
      laps_r  <= '0;
    end else begin
      state_r <= state_n;
      q_r     <= q_n;
      wrap_r  <= wrap_n;
      lap_r   <= lap_n;
      max_r   <= max_n;
      laps_r  <= laps_n;
    end
  end

  assign Q         = q_r;
  assign WRAP      = wrap_r;
  assign LAP_CNT   = lap_r;
  assign BUSY      = (state_r == S_RUN) || (state_r == S_PAUSE);
  assign DONE      = (state_r == S_DONE);
  assign state_dbg = state_r;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Bench for counter_run_ctrl: directed scenarios plus random control traffic,
// scored against a cycle-level reference model through an expected-value queue.
module tb_counter_run_ctrl;

  localparam int W = 10;
  localparam logic [4:0] C_NONE = 5'b00000, C_STEP = 5'b00001, C_START = 5'b00010,
                         C_PAUSE = 5'b00100, C_CLR = 5'b01000, C_RST = 5'b10000;

  logic       clk = 1'b0;
  logic       rst = 1'b0, start = 1'b0, pause = 1'b0, step = 1'b0, clr = 1'b0;
  logic [2:0] max_in = '0;
  logic [3:0] laps_in = '0;
  logic [2:0] q;
  logic       wrap;
  logic [3:0] lap_cnt;
  logic       busy, done;
  logic [1:0] state_dbg;

  counter_run_ctrl dut (
    .CLK(clk), .RST(rst), .START(start), .PAUSE(pause), .STEP(step), .CLR(clr),
    .MAX(max_in), .LAPS(laps_in), .Q(q), .WRAP(wrap), .LAP_CNT(lap_cnt),
    .BUSY(busy), .DONE(done), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // reference model state (0 idle, 1 run, 2 pause, 3 done)
  int         m_st = 0;
  logic [2:0] m_q = '0, m_max = 3'd6;
  logic       m_wrap = 1'b0;
  logic [3:0] m_lap = '0, m_laps = '0;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic adv;
    adv = 1'b0;
    if (rst) begin
      m_st = 0; m_q = '0; m_wrap = 1'b0; m_lap = '0; m_max = 3'd6; m_laps = '0;
    end else if (clr) begin
      m_st = 0; m_q = '0; m_wrap = 1'b0; m_lap = '0;
    end else begin
      m_wrap = 1'b0;
      if (m_st == 0 || m_st == 3) begin
        if (start) begin
          m_st = 1; m_max = (max_in == 3'd0) ? 3'd6 : max_in; m_laps = laps_in;
          m_q = '0; m_lap = '0;
        end
      end else if (m_st == 1) begin
        if (pause) m_st = 2; else adv = 1'b1;
      end else begin
        if (!pause && start) m_st = 1;
        else if (!pause && step) adv = 1'b1;
      end
      if (adv) begin
        if (m_q == m_max) begin
          m_q = '0; m_wrap = 1'b1; m_lap = m_lap + 4'd1;
          if (m_laps != 4'd0 && m_lap == m_laps) m_st = 3;
        end else begin
          m_q = m_q + 3'd1;
        end
      end
    end
  endtask

  // Drive one cycle of controls, predict, then compare just after the edge.
  task automatic tick(input string tag, input logic [4:0] c);
    logic [W-1:0] e;
    {rst, clr, pause, start, step} = c;
    model_step();
    exp_q.push_back({m_q, m_wrap, m_lap, (m_st == 1 || m_st == 2), (m_st == 3)});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(tag, {22'd0, q, wrap, lap_cnt, busy, done}, {22'd0, e});
  endtask

  int seq3[9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
  int step4[3] = '{5, 6, 0};

  initial begin
    int wraps;
    int qmax;

    // 1: reset with START held
    max_in = 3'd0; laps_in = 4'd0;
    tick("reset", C_RST | C_START);
    tick("reset", C_RST | C_START);
    check("reset_q", q, 0);
    check("reset_busy", busy, 0);

    // 2: default run, forever
    tick("def_start", C_START);
    check("def_start_q", q, 0);
    wraps = 0;
    for (int i = 0; i < 210; i++) begin
      tick("def_run", C_NONE);
      if (wrap) wraps++;
      if (done) check("def_no_done", done, 0);
    end
    check("def_wraps", wraps, 30);
    check("def_lapcnt", lap_cnt, 14);

    // 3: lap stop
    tick("clr", C_CLR);
    max_in = 3'd3; laps_in = 4'd2;
    tick("lap_start", C_START);
    check("lap_q0", q, seq3[0]);
    for (int i = 1; i < 9; i++) begin
      tick("lap_run", C_NONE);
      check("lap_q", q, seq3[i]);
    end
    check("lap_done", {done, busy, lap_cnt}, {1'b1, 1'b0, 4'd2});
    for (int i = 0; i < 3; i++) begin
      tick("lap_after", C_NONE);
      check("lap_after_q", q, 0);
    end

    // 4: pause / step / resume
    max_in = 3'd6; laps_in = 4'd0;
    tick("ps_start", C_START);
    for (int i = 0; i < 4; i++) tick("ps_run", C_NONE);
    check("ps_q4", q, 4);
    tick("ps_pause", C_PAUSE);
    for (int i = 0; i < 5; i++) begin
      tick("ps_hold", C_NONE);
      check("ps_hold_q", q, 4);
    end
    for (int i = 0; i < 3; i++) begin
      tick("ps_step", C_STEP);
      check("ps_step_q", q, step4[i]);
      check("ps_step_wrap", wrap, (i == 2));
    end
    tick("ps_resume", C_START);
    check("ps_resume_q", q, 0);
    tick("ps_adv", C_NONE);
    check("ps_adv_q", q, 1);

    // 5: priority
    tick("pr_clr_start", C_CLR | C_START);
    check("pr_clr_idle", {busy, q}, 4'b0000);
    tick("pr_start", C_START);
    tick("pr_run", C_NONE);
    tick("pr_run", C_NONE);
    tick("pr_pause_start", C_PAUSE | C_START);
    check("pr_paused_q", q, 2);
    tick("pr_hold", C_NONE);
    check("pr_hold_q", q, 2);
    tick("pr_start_step", C_START | C_STEP);
    check("pr_start_step_q", q, 2);
    tick("pr_run2", C_NONE);
    check("pr_run2_q", q, 3);

    // 6: mid-operation changes
    tick("mo_clr", C_CLR);
    max_in = 3'd6;
    tick("mo_start", C_START);
    max_in = 3'd2;
    qmax = 0;
    for (int i = 0; i < 14; i++) begin
      tick("mo_run", C_NONE);
      if (int'(q) > qmax) qmax = int'(q);
    end
    check("mo_qmax", qmax, 6);
    tick("mo_pause", C_PAUSE);
    tick("mo_rst", C_RST);
    check("mo_rst_out", {q, wrap, lap_cnt, busy, done}, 10'd0);
    max_in = 3'd1; laps_in = 4'd1;
    tick("mo_d_start", C_START);
    tick("mo_d_run", C_NONE);
    tick("mo_d_run", C_NONE);
    check("mo_done", {done, wrap, lap_cnt}, {1'b1, 1'b1, 4'd1});
    tick("mo_d_clr", C_CLR);
    check("mo_clr_idle", {done, busy, lap_cnt}, 6'd0);

    // random control traffic
    for (int i = 0; i < 400; i++) begin
      logic [4:0] c;
      c = C_NONE;
      if ($urandom_range(0, 99) < 2)  c = c | C_RST;
      if ($urandom_range(0, 99) < 4)  c = c | C_CLR;
      if ($urandom_range(0, 99) < 15) c = c | C_PAUSE;
      if ($urandom_range(0, 99) < 15) c = c | C_START;
      if ($urandom_range(0, 99) < 30) c = c | C_STEP;
      max_in  = 3'($urandom_range(0, 7));
      laps_in = 4'($urandom_range(0, 3));
      tick("random", c);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
